// File: rtl/trng_pkg.sv
// Shared constants, width defaults and FSM state encoding for the TRNG hash responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package trng_pkg;

    localparam int TRNG_DATA_WIDTH = 32;
    localparam int TRNG_WORDS      = 4;
    localparam int TRNG_ROUNDS     = 8;
    localparam int TRNG_ROTL       = 7;

    localparam logic [31:0] TRNG_IV = 32'h6A09E667;
    localparam logic [31:0] TRNG_K  = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } trng_state_e;

endpackage

// File: rtl/trng_mix_round.sv
// One mixing step: rotl(x,7) XOR (x + K), addition modulo 2^width.
// Latency: purely combinational.
// Backpressure: none; the output follows the input.
module trng_mix_round
    import trng_pkg::*;
#(
    parameter int P_DATA_WIDTH = TRNG_DATA_WIDTH
) (
    input  logic [P_DATA_WIDTH-1:0] mix_in,
    output logic [P_DATA_WIDTH-1:0] mix_out
);

    logic [P_DATA_WIDTH-1:0] rot_val;
    logic [P_DATA_WIDTH-1:0] sum_val;

    always_comb begin
        rot_val = (mix_in << TRNG_ROTL) | (mix_in >> (P_DATA_WIDTH - TRNG_ROTL));
        sum_val = mix_in + P_DATA_WIDTH'(TRNG_K);
        mix_out = rot_val ^ sum_val;
    end

endmodule

// File: rtl/trng_hash_responder.sv
// Absorbs P_WORDS entropy words into a mixed accumulator, runs P_ROUNDS extra mixes, publishes Digest.
// Latency: Hash_done in cycle 1+P_WORDS+P_ROUNDS after Hash_Go with no entropy stalls.
// Backpressure: Ent_Ready high only in ABSORB; Ent_Valid low stalls. Repeat-word health test under TRNG_HASH_HEALTH_EN.
module trng_hash_responder
    import trng_pkg::*;
#(
    parameter int P_DATA_WIDTH = TRNG_DATA_WIDTH,
    parameter int P_WORDS      = TRNG_WORDS,
    parameter int P_ROUNDS     = TRNG_ROUNDS
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    Hash_Go,
    output logic                    Hash_done,
    input  logic [P_DATA_WIDTH-1:0] Ent_Data,
    input  logic                    Ent_Valid,
    output logic                    Ent_Ready,
    output logic [P_DATA_WIDTH-1:0] Digest,
    output logic                    Busy,
    output logic                    Health_Fail
);

    localparam int WCW = $clog2(P_WORDS + 1);
    localparam int RCW = $clog2(P_ROUNDS + 1);

    trng_state_e             state_q, state_d;
    logic [P_DATA_WIDTH-1:0] acc_q, acc_d;
    logic [P_DATA_WIDTH-1:0] digest_q, digest_d;
    logic [WCW-1:0]          word_cnt_q, word_cnt_d;
    logic [RCW-1:0]          round_cnt_q, round_cnt_d;
    logic                    hash_done_q, hash_done_d;
    logic [P_DATA_WIDTH-1:0] mix_in;
    logic [P_DATA_WIDTH-1:0] mix_out;
    logic                    req_bad;

    // Single mixer shared by absorb (acc ^ word) and round (acc) paths.
    trng_mix_round #(
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_mix (
        .mix_in  (mix_in),
        .mix_out (mix_out)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        digest_d    = digest_q;
        word_cnt_d  = word_cnt_q;
        round_cnt_d = round_cnt_q;
        hash_done_d = 1'b0;
        mix_in      = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (Hash_Go) begin
                    state_d     = ST_ABSORB;
                    acc_d       = P_DATA_WIDTH'(TRNG_IV);
                    word_cnt_d  = '0;
                    round_cnt_d = '0;
                end
            end
            ST_ABSORB: begin
                mix_in = acc_q ^ Ent_Data;
                if (Ent_Valid) begin
                    acc_d      = mix_out;
                    word_cnt_d = word_cnt_q + WCW'(1);
                    if (word_cnt_q == WCW'(P_WORDS - 1)) begin
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                acc_d       = mix_out;
                round_cnt_d = round_cnt_q + RCW'(1);
                // Digest is captured on the edge into DONE so it is valid alongside Hash_done.
                if (round_cnt_q == RCW'(P_ROUNDS - 1)) begin
                    state_d     = ST_DONE;
                    hash_done_d = 1'b1;
                    digest_d    = req_bad ? '0 : mix_out;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            digest_q    <= '0;
            word_cnt_q  <= '0;
            round_cnt_q <= '0;
            hash_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            digest_q    <= digest_d;
            word_cnt_q  <= word_cnt_d;
            round_cnt_q <= round_cnt_d;
            hash_done_q <= hash_done_d;
        end
    end

`ifdef TRNG_HASH_HEALTH_EN
    logic [P_DATA_WIDTH-1:0] prev_word_q, prev_word_d;
    logic                    req_bad_q, req_bad_d;
    logic                    health_fail_q, health_fail_d;
    logic                    rep_hit;

    // A repeat is only meaningful from the second accepted word of the same request.
    always_comb begin
        rep_hit       = (state_q == ST_ABSORB) && Ent_Valid && (word_cnt_q != '0)
                        && (Ent_Data == prev_word_q);
        prev_word_d   = ((state_q == ST_ABSORB) && Ent_Valid) ? Ent_Data : prev_word_q;
        req_bad_d     = req_bad_q;
        if ((state_q == ST_IDLE) && Hash_Go) begin
            req_bad_d = 1'b0;
        end else if (rep_hit) begin
            req_bad_d = 1'b1;
        end
        health_fail_d = health_fail_q | rep_hit;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            prev_word_q   <= '0;
            req_bad_q     <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            prev_word_q   <= prev_word_d;
            req_bad_q     <= req_bad_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign req_bad     = req_bad_q;
    assign Health_Fail = health_fail_q;
`else
    assign req_bad     = 1'b0;
    assign Health_Fail = 1'b0;
`endif

    assign Hash_done = hash_done_q;
    assign Digest    = digest_q;
    assign Ent_Ready = (state_q == ST_ABSORB);
    assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trng_hash_responder.sv
// Directed bench for trng_hash_responder: vector table of requests plus hand sequences for Go-ignore and mid-request reset.
module tb_trng_hash_responder;

    localparam int W = 32;

`ifdef TRNG_HASH_HEALTH_EN
    localparam int HF_NEW    = 3;
    localparam int HF_STICKY = 1;
`else
    localparam int HF_NEW    = -1;
    localparam int HF_STICKY = -1;
`endif

    logic         clk = 1'b0;
    logic         Reset;
    logic         Hash_Go;
    logic         Hash_done;
    logic [W-1:0] Ent_Data;
    logic         Ent_Valid;
    logic         Ent_Ready;
    logic [W-1:0] Digest;
    logic         Busy;
    logic         Health_Fail;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    trng_hash_responder dut (
        .clk         (clk),
        .Reset       (Reset),
        .Hash_Go     (Hash_Go),
        .Hash_done   (Hash_done),
        .Ent_Data    (Ent_Data),
        .Ent_Valid   (Ent_Valid),
        .Ent_Ready   (Ent_Ready),
        .Digest      (Digest),
        .Busy        (Busy),
        .Health_Fail (Health_Fail)
    );

    typedef struct packed {
        logic [3:0][31:0] w;
        int               stall_after;
        int               stall_len;
        int               exp_done;
        int               exp_hf;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mix(input logic [31:0] x);
        return {x[24:0], x[31:25]} ^ (x + 32'h9E3779B9);
    endfunction

    function automatic logic has_repeat(input logic [3:0][31:0] w);
        logic r = 1'b0;
        for (int i = 1; i < 4; i++) if (w[i] == w[i-1]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [3:0][31:0] w);
        logic [31:0] a = 32'h6A09E667;
        for (int i = 0; i < 4; i++) a = mix(a ^ w[i]);
        for (int r = 0; r < 8; r++) a = mix(a);
`ifdef TRNG_HASH_HEALTH_EN
        if (has_repeat(w)) a = '0;
`endif
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_vec(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input int sa,
                           input int sl, input int ed, input int hf);
        tbl[idx].w[0]        = a;
        tbl[idx].w[1]        = b;
        tbl[idx].w[2]        = c;
        tbl[idx].w[3]        = d;
        tbl[idx].stall_after = sa;
        tbl[idx].stall_len   = sl;
        tbl[idx].exp_done    = ed;
        tbl[idx].exp_hf      = hf;
    endtask

    // Runs one request with Hash_Go at cycle 0; Ent_Valid is held high outside the stall window.
    task automatic run_req(input vec_t v, output int done_cnt, output int done_cyc,
                           output int ready_cnt, output int ready_first, output int hf_first,
                           output logic busy_done, output logic [31:0] dig);
        int widx = 0;
        int gap  = 0;
        done_cnt = 0; done_cyc = -1; ready_cnt = 0; ready_first = -1; hf_first = -1;
        busy_done = 1'b0; dig = '0;
        cyc = 0;
        Hash_Go = 1'b1; Ent_Valid = 1'b0;
        step();
        Hash_Go = 1'b0;
        while (cyc < v.exp_done + 4) begin
            if (Ent_Ready) begin
                ready_cnt++;
                if (ready_first < 0) ready_first = cyc;
            end
            if (Hash_done) begin
                done_cnt++; done_cyc = cyc; dig = Digest; busy_done = Busy;
            end
            if (Health_Fail && hf_first < 0) hf_first = cyc;
            if (widx == v.stall_after && gap < v.stall_len) begin
                Ent_Valid = 1'b0;
                gap++;
            end else begin
                Ent_Valid = 1'b1;
                if (widx < 4) Ent_Data = v.w[widx];
                else          Ent_Data = 32'hDEADBEEF;
                if (Ent_Ready) widx++;
            end
            step();
        end
        Ent_Valid = 1'b0;
    endtask

    initial begin
        int          dc, dcy, rc, rf, hff;
        logic        bd;
        logic [31:0] dg;
        logic [3:0][31:0] w1234;

        Reset = 1'b1; Hash_Go = 1'b0; Ent_Valid = 1'b0; Ent_Data = '0;
        step(); step(); step();
        check("reset_hash_done", {31'd0, Hash_done}, 32'd0);
        check("reset_ent_ready", {31'd0, Ent_Ready}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_digest", Digest, 32'd0);
        check("reset_health", {31'd0, Health_Fail}, 32'd0);
        Reset = 1'b0;
        step();

        set_vec(0, 32'd1, 32'd2, 32'd3, 32'd4, 99, 0, 13, -1);
        set_vec(1, 32'd1, 32'd2, 32'd3, 32'd4, 2, 3, 16, -1);
        set_vec(2, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h12345678, 0, 2, 15, -1);
        set_vec(3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 1, 14, -1);
        set_vec(4, 32'd5, 32'd5, 32'd7, 32'd9, 99, 0, 13, HF_NEW);
        set_vec(5, 32'd1, 32'd2, 32'd3, 32'd4, 99, 0, 13, HF_STICKY);

        for (int i = 0; i < 6; i++) begin
            run_req(tbl[i], dc, dcy, rc, rf, hff, bd, dg);
            check($sformatf("v%0d_done_count", i), dc, 1);
            check($sformatf("v%0d_done_cycle", i), dcy, tbl[i].exp_done);
            check($sformatf("v%0d_digest", i), dg, model(tbl[i].w));
            check($sformatf("v%0d_ready_count", i), rc, 4 + tbl[i].stall_len);
            check($sformatf("v%0d_ready_first", i), rf, 1);
            check($sformatf("v%0d_health_first", i), hff, tbl[i].exp_hf);
            check($sformatf("v%0d_busy_at_done", i), {31'd0, bd}, 32'd1);
            check($sformatf("v%0d_busy_after", i), {31'd0, Busy}, 32'd0);
        end

        // Hash_Go pulsed again in cycle 5 (ABSORB... ROUND) and cycle 13 (DONE) must not queue.
        w1234 = tbl[0].w;
        dc = 0; dcy = -1; rc = 0; dg = '0;
        begin
            int widx = 0;
            cyc = 0;
            Hash_Go = 1'b1;
            step();
            while (cyc < 30) begin
                if (Ent_Ready) rc++;
                if (Hash_done) begin dc++; dcy = cyc; dg = Digest; end
                if (cyc == 16) check("go_ignore_busy_c16", {31'd0, Busy}, 32'd0);
                Hash_Go = (cyc == 5 || cyc == 13);
                Ent_Valid = 1'b1;
                Ent_Data = (widx < 4) ? w1234[widx] : 32'h0BADF00D;
                if (Ent_Ready) widx++;
                step();
            end
            Hash_Go = 1'b0; Ent_Valid = 1'b0;
        end
        check("go_ignore_done_count", dc, 1);
        check("go_ignore_done_cycle", dcy, 13);
        check("go_ignore_ready_count", rc, 4);
        check("go_ignore_digest", dg, model(w1234));

        // Reset sampled at cycle 8 while in ROUND aborts with no pulse.
        dc = 0;
        cyc = 0;
        Hash_Go = 1'b1;
        step();
        Hash_Go = 1'b0;
        begin
            int widx = 0;
            while (cyc < 8) begin
                if (Hash_done) dc++;
                Ent_Valid = 1'b1;
                Ent_Data = (widx < 4) ? w1234[widx] : 32'h0;
                if (Ent_Ready) widx++;
                step();
            end
        end
        Ent_Valid = 1'b0;
        Reset = 1'b1;
        step();
        check("abort_busy_c9", {31'd0, Busy}, 32'd0);
        check("abort_digest_c9", Digest, 32'd0);
        check("abort_ready_c9", {31'd0, Ent_Ready}, 32'd0);
        check("abort_health_cleared", {31'd0, Health_Fail}, 32'd0);
        Reset = 1'b0;
        while (cyc < 30) begin
            if (Hash_done) dc++;
            step();
        end
        check("abort_done_count", dc, 0);
        check("abort_busy_end", {31'd0, Busy}, 32'd0);
        check("abort_digest_end", Digest, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
